flag_cross_arbiter: RTL and testbench
=====================================

# flag_cross_arbiter

- Shares one toggle/acknowledge flag-crossing channel among `NUM_REQ` requesters in clock domain A.
- Captures per-requester event pulses into pending bits.
- Picks one pending requester round-robin, launches a single-cycle flag into the crossing, then waits for the crossing's busy indication to clear before reporting completion.
- Sits directly in front of the crossing channel's A-side `FlagIn_clkA`/`Busy_clkA` pair; it guarantees that a flag is never launched while the channel is busy, so no event is lost.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.
- `TIMEOUT_CYCLES`, default 255: number of WAIT cycles before `timeout_err` sets; 1..65535.

Ports:
- `clkA`  in  1  domain-A clock; the block's only clock.
- `rstA_n`  in  1  reset; asynchronous, active-low.
- `req_clkA`  in  NUM_REQ  per-requester event pulse; each cycle high counts as one event.
- `grant_clkA`  out  NUM_REQ  one-hot; high during the launch cycle for the selected requester.
- `done_clkA`  out  NUM_REQ  one-hot, one-cycle pulse when the selected requester's crossing has completed.
- `pending_clkA`  out  NUM_REQ  registered pending bits.
- `inflight_id`  out  ID_W  index of the requester currently launched or waiting; holds its last value in IDLE.
- `timeout_err`  out  1  sticky error flag.
- `err_clr`  in  1  clears `timeout_err`.
- `FlagIn_clkA`  out  1  to the crossing channel; high for exactly one cycle per launch.
- `Busy_clkA`  in  1  from the crossing channel.

## Operation
- **Pending capture:**
  - `pending[i]` sets on any edge where `req_clkA[i]=1`.
  - It clears on the edge that selects `i`.
  - If set and clear coincide, set wins: a request arriving on its own grant edge re-pends.
  - Repeated requests while pending coalesce into one launch.
- **States:** IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH when `pending≠0` and `Busy_clkA=0`. On that edge: latch the winner into `inflight_id`, clear its pending bit, set the round-robin pointer to winner+1 mod NUM_REQ.
  - IDLE with `Busy_clkA=1` (e.g. asymmetric reset of the two domains) holds; no launch.
  - LAUNCH → WAIT unconditionally. Outputs during the LAUNCH cycle: `FlagIn_clkA=1` and `grant_clkA[inflight_id]=1`, both decoded from state, zero-latency.
  - WAIT → IDLE on the first edge with `Busy_clkA=0`. On that edge `done_clkA[inflight_id]` registers high for one cycle.
- **Round-robin:** search starts at the pointer and wraps. After reset the pointer is 0, so requester 0 has first priority.
- **Timeout:**
  - A 16-bit counter clears on LAUNCH and counts WAIT cycles, saturating.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_err` sets.
  - The FSM keeps waiting; an in-flight crossing is never aborted.
  - `err_clr` clears the flag; if the set condition occurs on the same edge, set wins.
- **Reset:** mid-operation reset returns to IDLE immediately and discards all pending and in-flight state. Outputs while reset is asserted:
  - `grant_clkA`, `done_clkA`, `pending_clkA` = 0
  - `inflight_id` = 0
  - `timeout_err` = 0
  - `FlagIn_clkA` = 0

## Timing
- `req_clkA[i]` high at edge t → `pending[i]=1` after t.
- Selection at edge t+1 if IDLE and not busy.
- LAUNCH cycle is t+1..t+2: `FlagIn_clkA` and `grant` high.
- WAIT begins at t+2.
- `Busy_clkA` is expected high from the cycle after LAUNCH; WAIT never exits before sampling `Busy_clkA` low at least once.
- Busy low sampled at edge u → `done` high during u..u+1, state IDLE.
- Next launch is no earlier than edge u+1, i.e. at least one IDLE cycle between crossings.
- Minimum spacing between successive `FlagIn_clkA` pulses is 3 cycles plus channel round-trip.

## Structure
- `flag_cross_pkg` holds:
  - state enum `fca_state_e` {IDLE, LAUNCH, WAIT}
  - timeout counter width constant (16)
- One combinational sub-module `rr_picker`:
  - Inputs: `req` vector and pointer.
  - Outputs: one-hot winner, winner index, `any` flag.
  - Reusable by other arbiters in the design.

## Test plan
- Single request: pulse `req[2]` → `grant[2]` and `FlagIn_clkA` high for one cycle at t+1; after the model's busy drops, `done[2]` pulses once; `inflight_id=2`.
- All four requesting simultaneously from reset → grants in order 0,1,2,3; each `done` precedes the next `grant`; no `FlagIn_clkA` while `Busy_clkA=1`.
- Coalesce and re-pend:
  - `req[1]` pulsed 3 times while pending → one launch.
  - `req[1]` on its own grant edge → a second launch later.
- Timeout: `TIMEOUT_CYCLES=8`, hold `Busy_clkA=1` → `timeout_err=1` after 8 WAIT cycles and the FSM stays in WAIT. Then release busy → `done` pulses; `err_clr` clears the flag.
- Busy high in IDLE with `pending=0001` → no launch until busy falls, then launch on the next edge.
- Assert `rstA_n` low during WAIT → all outputs 0 asynchronously; after release, the old pending requests are gone and the pointer is back at 0.

Source files
------------

// File: rtl/flag_cross_arbiter_pkg.sv
// Shared types and constants for the flag-crossing arbiter and its helpers.
// Holds the FSM state encoding, the timeout counter width and the pointer wrap helper.
package flag_cross_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } fca_state_e;

   localparam int TMO_CNT_W = 16;

   // Advance a round-robin index by one, wrapping at n.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/flag_cross_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// with the search wrapping past the top index.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int  pos;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[pos]) begin
            grant[pos] = 1'b1;
            idx        = ID_W'(pos);
            found      = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/flag_cross_arbiter.sv
// Shares one toggle/ack flag-crossing channel among NUM_REQ domain-A requesters:
// pending capture, round-robin launch, busy-gated completion and a sticky wait timeout.
module flag_cross_arbiter
   import flag_cross_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clkA,
   input  logic               rstA_n,
   input  logic [NUM_REQ-1:0] req_clkA,
   output logic [NUM_REQ-1:0] grant_clkA,
   output logic [NUM_REQ-1:0] done_clkA,
   output logic [NUM_REQ-1:0] pending_clkA,
   output logic [ID_W-1:0]    inflight_id,
   output logic               timeout_err,
   input  logic               err_clr,
   output logic               FlagIn_clkA,
   input  logic               Busy_clkA
);

   localparam logic [TMO_CNT_W-1:0] TMO = TMO_CNT_W'(TIMEOUT_CYCLES);

   fca_state_e             state;
   fca_state_e             state_next;
   logic [ID_W-1:0]        ptr;
   logic [ID_W-1:0]        next_ptr;
   logic [NUM_REQ-1:0]     pick_grant;
   logic [ID_W-1:0]        pick_idx;
   logic                   pick_any;
   logic [NUM_REQ-1:0]     id_onehot;
   logic [NUM_REQ-1:0]     clr_mask;
   logic [TMO_CNT_W-1:0]   wait_cnt;
   logic [TMO_CNT_W-1:0]   wait_inc;
   logic                   launch_go;
   logic                   wait_exit;
   logic                   err_set;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req   (pending_clkA),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         id_onehot[i] = (inflight_id == ID_W'(i));
      end
   end

   assign launch_go = (state == IDLE) && pick_any && !Busy_clkA;
   assign wait_exit = (state == WAIT) && !Busy_clkA;
   assign clr_mask  = launch_go ? pick_grant : '0;
   assign next_ptr  = ID_W'(wrap_inc(int'(pick_idx), NUM_REQ));

   // Saturating count of WAIT cycles; the error fires once, on the cycle the limit is reached.
   assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
   assign err_set  = (state == WAIT) && (wait_inc == TMO) && (wait_cnt != TMO);

   always_comb begin
      state_next  = state;
      grant_clkA  = '0;
      FlagIn_clkA = 1'b0;
      case (state)
         IDLE: begin
            if (launch_go) state_next = LAUNCH;
         end
         LAUNCH: begin
            FlagIn_clkA = 1'b1;
            grant_clkA  = id_onehot;
            state_next  = WAIT;
         end
         WAIT: begin
            if (!Busy_clkA) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clkA or negedge rstA_n) begin
      if (!rstA_n) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_next;
         if (launch_go) ptr <= next_ptr;
      end
   end

   // A request landing on its own selection edge re-pends: set is ORed in after the clear.
   always_ff @(posedge clkA or negedge rstA_n) begin
      if (!rstA_n) begin
         pending_clkA <= '0;
         inflight_id  <= '0;
         done_clkA    <= '0;
      end else begin
         pending_clkA <= (pending_clkA & ~clr_mask) | req_clkA;
         if (launch_go) inflight_id <= pick_idx;
         done_clkA <= wait_exit ? id_onehot : '0;
      end
   end

   always_ff @(posedge clkA or negedge rstA_n) begin
      if (!rstA_n) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == LAUNCH) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_inc;
         end
         if (err_set) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_flag_cross_arbiter.sv
// Bench for flag_cross_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_flag_cross_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int TO = 8;

   logic          clkA = 1'b0;
   logic          rstA_n;
   logic [N-1:0]  req_clkA;
   logic [N-1:0]  grant_clkA;
   logic [N-1:0]  done_clkA;
   logic [N-1:0]  pending_clkA;
   logic [IW-1:0] inflight_id;
   logic          timeout_err;
   logic          err_clr;
   logic          FlagIn_clkA;
   logic          Busy_clkA;

   always #5 clkA = ~clkA;

   flag_cross_arbiter #(
      .NUM_REQ        (N),
      .ID_W           (IW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clkA         (clkA),
      .rstA_n       (rstA_n),
      .req_clkA     (req_clkA),
      .grant_clkA   (grant_clkA),
      .done_clkA    (done_clkA),
      .pending_clkA (pending_clkA),
      .inflight_id  (inflight_id),
      .timeout_err  (timeout_err),
      .err_clr      (err_clr),
      .FlagIn_clkA  (FlagIn_clkA),
      .Busy_clkA    (Busy_clkA)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: the set of pending requesters, the crossing currently owned,
   // how long it has been waiting, and which requester just completed.
   bit m_pend [N];
   bit m_launching;
   bit m_waiting;
   int m_id;
   int m_ptr;
   int m_wait_cycles;
   int m_done;
   bit m_err;

   bit auto_busy = 1'b1;
   int busy_left = 0;
   int busy_max  = 4;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_launching   = 1'b0;
      m_waiting     = 1'b0;
      m_id          = 0;
      m_ptr         = 0;
      m_wait_cycles = 0;
      m_done        = -1;
      m_err         = 1'b0;
   endfunction

   function automatic void model_edge(input logic [N-1:0] r, input logic b, input logic clr);
      bit set_err;
      int prev;
      set_err = 1'b0;
      m_done  = -1;
      if (m_launching) begin
         m_launching   = 1'b0;
         m_waiting     = 1'b1;
         m_wait_cycles = 0;
      end else if (m_waiting) begin
         prev = m_wait_cycles;
         if (m_wait_cycles < 65535) m_wait_cycles++;
         if (m_wait_cycles == TO && prev != TO) set_err = 1'b1;
         if (!b) begin
            m_waiting = 1'b0;
            m_done    = m_id;
         end
      end else if (!b) begin
         for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (m_pend[p]) begin
               m_id        = p;
               m_ptr       = (p + 1) % N;
               m_pend[p]   = 1'b0;
               m_launching = 1'b1;
               break;
            end
         end
      end
      for (int i = 0; i < N; i++) if (r[i]) m_pend[i] = 1'b1;
      if (set_err) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
   endfunction

   function automatic logic [N-1:0] mask(input int id);
      logic [N-1:0] m;
      m = '0;
      if (id >= 0) m[id] = 1'b1;
      return m;
   endfunction

   function automatic logic [N-1:0] pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("grant",       32'(grant_clkA),   32'(m_launching ? mask(m_id) : '0));
      chk("flag_in",     32'(FlagIn_clkA),  32'(m_launching));
      chk("done",        32'(done_clkA),    32'(mask(m_done)));
      chk("pending",     32'(pending_clkA), 32'(pend_vec()));
      chk("inflight_id", 32'(inflight_id),  32'(m_id));
      chk("timeout_err", 32'(timeout_err),  32'(m_err));
      chk("flag_while_busy", 32'(FlagIn_clkA & Busy_clkA), 32'(0));
   endtask

   // One clock: apply inputs, advance model on the edge, compare 1 time unit later,
   // then let the channel stand-in decide busy for the next edge.
   task automatic step(input logic [N-1:0] r, input logic clr);
      req_clkA = r;
      err_clr  = clr;
      @(posedge clkA);
      model_edge(r, Busy_clkA, clr);
      #1;
      check_all();
      req_clkA = '0;
      err_clr  = 1'b0;
      if (auto_busy) begin
         if (m_waiting && m_wait_cycles == 0) begin
            busy_left = $urandom_range(0, busy_max);
            Busy_clkA = (busy_left != 0);
         end else if (busy_left > 0) begin
            busy_left--;
            Busy_clkA = (busy_left != 0);
         end
      end
   endtask

   task automatic run_idle(input int n);
      repeat (n) step('0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clkA);
      rstA_n    = 1'b0;
      Busy_clkA = 1'b0;
      busy_left = 0;
      #1;
      model_reset();
      check_all();
      @(negedge clkA);
      rstA_n = 1'b1;
   endtask

   initial begin
      rstA_n    = 1'b0;
      req_clkA  = '0;
      err_clr   = 1'b0;
      Busy_clkA = 1'b0;
      model_reset();
      #2;
      check_all();
      @(negedge clkA);
      rstA_n = 1'b1;

      // Single request on requester 2
      step(4'b0100, 1'b0);
      run_idle(10);

      // All four from reset: served 0,1,2,3
      do_reset();
      step(4'b1111, 1'b0);
      run_idle(40);

      // Busy held in IDLE: repeated req[1] coalesces, launch only once busy falls
      auto_busy = 1'b0;
      busy_left = 0;
      Busy_clkA = 1'b1;
      step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      run_idle(2);
      Busy_clkA = 1'b0;
      auto_busy = 1'b1;
      run_idle(10);

      // Request on its own selection edge re-pends
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      run_idle(16);

      // Busy in IDLE with only requester 0 pending
      auto_busy = 1'b0;
      Busy_clkA = 1'b1;
      step(4'b0001, 1'b0);
      run_idle(3);
      Busy_clkA = 1'b0;
      auto_busy = 1'b1;
      run_idle(8);

      // Timeout: busy held through the whole wait, then released and cleared
      auto_busy = 1'b0;
      busy_left = 0;
      Busy_clkA = 1'b0;
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      Busy_clkA = 1'b1;
      run_idle(12);
      Busy_clkA = 1'b0;
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      run_idle(2);

      // Reset while waiting discards pending and in-flight state
      step(4'b1110, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      Busy_clkA = 1'b1;
      run_idle(2);
      do_reset();
      auto_busy = 1'b1;
      step(4'b1010, 1'b0);
      run_idle(16);

      // Random traffic with occasional long busy periods and error clears
      busy_max = 11;
      repeat (400) begin
         logic [N-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         step(r, ($urandom_range(0, 15) == 0));
      end
      run_idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
